// File: rtl/execute_stage_mdu.sv
// Execute stage: single-cycle RV ALU, branch and address operations, plus an iterative
// M-extension unit (shift-add multiply, restoring divide). Valid/ready on both sides;
// stall is high while a multi-cycle operation occupies the unit.

package execute_stage_mdu_pkg;

  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } decoded_instr_name;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } mdu_state_e;

endpackage

module execute_stage_mdu
  import execute_stage_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 4,
  parameter int RD_W    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  decoded_instr_name in_op,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc_plus_4,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wbv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wbv,
  output logic              out_is_load,
  output decoded_instr_name out_op,
  output logic              stall
);

  localparam int SH_W      = $clog2(XLEN);
  localparam int CNT_W     = $clog2(XLEN);
  localparam int MUL_STEPS = XLEN / MUL_BPC;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Iterative datapath: op_a is multiplicand or divisor magnitude; acc_hi/acc_lo hold the
  // running product (hi:lo) or remainder (hi) and dividend/quotient (lo).
  logic [XLEN-1:0] op_a_q, acc_hi_q, acc_lo_q;
  logic            neg_q, neg_r_q;

  // Operation fields captured at accept, held until the iterative result retires.
  decoded_instr_name pend_op_q;
  logic [RD_W-1:0]   pend_rd_q;
  logic              pend_wbv_q;
  logic [XLEN-1:0]   pend_sd_q;

  logic              out_valid_q, out_wbv_q;
  logic [XLEN-1:0]   out_result_q, out_store_data_q;
  logic [RD_W-1:0]   out_rd_q;
  decoded_instr_name out_op_q;

  // Input decode and handshake
  logic is_mul_op, is_div_op, is_signed_div, is_quot_op, div_zero, div_ovf;
  logic out_free, accept, start_mul, start_div, single_load;
  logic last_step, mdu_step, mdu_done;

  assign is_mul_op     = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign is_div_op     = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_signed_div = in_op inside {OP_DIV, OP_REM};
  assign is_quot_op    = in_op inside {OP_DIV, OP_DIVU};
  assign div_zero      = (in_rs2 == '0);
  assign div_ovf       = is_signed_div && (in_rs1 == MIN_VAL) && (in_rs2 == '1);

  assign out_free    = !out_valid_q || out_ready;
  assign in_ready    = (state_q == ST_IDLE) && out_free;
  assign accept      = in_valid && in_ready && !flush;
  assign start_mul   = accept && is_mul_op;
  assign start_div   = accept && is_div_op && !div_zero && !div_ovf;
  assign single_load = accept && !start_mul && !start_div;

  // The final step also writes the output register, so it waits for the output to free.
  assign last_step = ((state_q == ST_MUL) && (cnt_q == CNT_W'(MUL_STEPS - 1))) ||
                     ((state_q == ST_DIV) && (cnt_q == CNT_W'(XLEN - 1)));
  assign mdu_step  = (state_q != ST_IDLE) && !flush && (!last_step || out_free);
  assign mdu_done  = mdu_step && last_step;
  assign stall     = (state_q != ST_IDLE);

  // Single-cycle ALU / branch / address result
  logic [XLEN-1:0] alu_result, fast_result;
  logic [SH_W-1:0] shamt_r, shamt_i;
  assign shamt_r = in_rs2[SH_W-1:0];
  assign shamt_i = in_imm[SH_W-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alu_result = '0;
    case (in_op)
      OP_LUI:                                   alu_result = in_imm;
      OP_AUIPC:                                 alu_result = in_pc_plus_4 - XLEN'(4) + in_imm;
      OP_JAL, OP_JALR:                          alu_result = in_pc_plus_4;
      OP_BEQ:                                   alu_result = XLEN'(in_rs1 == in_rs2);
      OP_BNE:                                   alu_result = XLEN'(in_rs1 != in_rs2);
      OP_BLT:                                   alu_result = XLEN'($signed(in_rs1) < $signed(in_rs2));
      OP_BGE:                                   alu_result = XLEN'($signed(in_rs1) >= $signed(in_rs2));
      OP_BLTU:                                  alu_result = XLEN'(in_rs1 < in_rs2);
      OP_BGEU:                                  alu_result = XLEN'(in_rs1 >= in_rs2);
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_ADDI:             alu_result = in_rs1 + in_imm;
      OP_SLTI:                                  alu_result = XLEN'($signed(in_rs1) < $signed(in_imm));
      OP_SLTIU:                                 alu_result = XLEN'(in_rs1 < in_imm);
      OP_XORI:                                  alu_result = in_rs1 ^ in_imm;
      OP_ORI:                                   alu_result = in_rs1 | in_imm;
      OP_ANDI:                                  alu_result = in_rs1 & in_imm;
      OP_SLLI:                                  alu_result = in_rs1 << shamt_i;
      OP_SRLI:                                  alu_result = in_rs1 >> shamt_i;
      OP_SRAI:                                  alu_result = $signed(in_rs1) >>> shamt_i;
      OP_ADD:                                   alu_result = in_rs1 + in_rs2;
      OP_SUB:                                   alu_result = in_rs1 - in_rs2;
      OP_SLL:                                   alu_result = in_rs1 << shamt_r;
      OP_SLT:                                   alu_result = XLEN'($signed(in_rs1) < $signed(in_rs2));
      OP_SLTU:                                  alu_result = XLEN'(in_rs1 < in_rs2);
      OP_XOR:                                   alu_result = in_rs1 ^ in_rs2;
      OP_SRL:                                   alu_result = in_rs1 >> shamt_r;
      OP_SRA:                                   alu_result = $signed(in_rs1) >>> shamt_r;
      OP_OR:                                    alu_result = in_rs1 | in_rs2;
      OP_AND:                                   alu_result = in_rs1 & in_rs2;
      default:                                  alu_result = '0;
    endcase
  end

  // Result of any op that retires at the accept edge (ALU, or a degenerate divide)
  always_comb begin
    fast_result = alu_result;
    if (is_div_op) begin
      if (div_zero)     fast_result = is_quot_op ? '1 : in_rs1;
      else if (div_ovf) fast_result = is_quot_op ? MIN_VAL : '0;
    end
  end

  // Operand magnitudes and result sign flags captured when an iterative op starts
  logic            rs1_neg, rs2_neg, mul_a_signed, mul_b_signed;
  logic [XLEN-1:0] mag1, mag2;
  assign rs1_neg      = in_rs1[XLEN-1];
  assign rs2_neg      = in_rs2[XLEN-1];
  assign mag1         = rs1_neg ? -in_rs1 : in_rs1;
  assign mag2         = rs2_neg ? -in_rs2 : in_rs2;
  assign mul_a_signed = in_op inside {OP_MULH, OP_MULHSU};
  assign mul_b_signed = (in_op == OP_MULH);

  // One iteration step of the multiplier and divider, plus final sign fix-up
  logic [XLEN+MUL_BPC-1:0] mul_sum;
  logic [2*XLEN-1:0]       mul_next, prod;
  logic [XLEN:0]           div_shift, div_diff;
  logic [XLEN-1:0]         div_rem_next, div_quo_next, mdu_result;

  always_comb begin
    mul_sum = {{MUL_BPC{1'b0}}, acc_hi_q};
    for (int j = 0; j < MUL_BPC; j++) begin
      if (acc_lo_q[j]) mul_sum = mul_sum + ({{MUL_BPC{1'b0}}, op_a_q} << j);
    end
    mul_next = {mul_sum, acc_lo_q[XLEN-1:MUL_BPC]};
    prod     = neg_q ? -mul_next : mul_next;

    div_shift    = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff     = div_shift - {1'b0, op_a_q};
    div_rem_next = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    div_quo_next = {acc_lo_q[XLEN-2:0], ~div_diff[XLEN]};

    if (state_q == ST_MUL) begin
      mdu_result = (pend_op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (pend_op_q inside {OP_DIV, OP_DIVU}) begin
      mdu_result = neg_q ? -div_quo_next : div_quo_next;
    end else begin
      mdu_result = neg_r_q ? -div_rem_next : div_rem_next;
    end
  end

  // FSM next state and step counter; flush wins over start and completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (start_mul)      state_d = ST_MUL;
          else if (start_div) state_d = ST_DIV;
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (mdu_step) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Iterative datapath: load operands on start, advance one step per enabled cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      pend_op_q  <= OP_NOP;
      pend_rd_q  <= '0;
      pend_wbv_q <= 1'b0;
      pend_sd_q  <= '0;
    end else if (start_mul || start_div) begin
      acc_hi_q   <= '0;
      pend_op_q  <= in_op;
      pend_rd_q  <= in_rd;
      pend_wbv_q <= in_wbv;
      pend_sd_q  <= in_rs2;
      if (start_mul) begin
        op_a_q   <= mul_a_signed ? mag1 : in_rs1;
        acc_lo_q <= mul_b_signed ? mag2 : in_rs2;
        neg_q    <= (mul_a_signed && rs1_neg) ^ (mul_b_signed && rs2_neg);
        neg_r_q  <= 1'b0;
      end else begin
        op_a_q   <= is_signed_div ? mag2 : in_rs2;
        acc_lo_q <= is_signed_div ? mag1 : in_rs1;
        neg_q    <= is_signed_div && (rs1_neg ^ rs2_neg);
        neg_r_q  <= is_signed_div && rs1_neg;
      end
    end else if (mdu_step) begin
      if (state_q == ST_MUL) begin
        acc_hi_q <= mul_next[2*XLEN-1:XLEN];
        acc_lo_q <= mul_next[XLEN-1:0];
      end else begin
        acc_hi_q <= div_rem_next;
        acc_lo_q <= div_quo_next;
      end
    end
  end

  // Output register: load on single-cycle accept or MDU completion, hold while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_store_data_q <= '0;
      out_rd_q         <= '0;
      out_wbv_q        <= 1'b0;
      out_op_q         <= OP_NOP;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (mdu_done) begin
      out_valid_q      <= 1'b1;
      out_result_q     <= mdu_result;
      out_store_data_q <= pend_sd_q;
      out_rd_q         <= pend_rd_q;
      out_wbv_q        <= pend_wbv_q;
      out_op_q         <= pend_op_q;
    end else if (single_load) begin
      out_valid_q      <= 1'b1;
      out_result_q     <= fast_result;
      out_store_data_q <= in_rs2;
      out_rd_q         <= in_rd;
      out_wbv_q        <= in_wbv;
      out_op_q         <= in_op;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_store_data = out_store_data_q;
  assign out_rd         = out_rd_q;
  assign out_wbv        = out_wbv_q;
  assign out_op         = out_op_q;
  assign out_is_load    = out_op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Bench for execute_stage_mdu: transaction-level model (result by plain arithmetic,
// latency as a countdown), per-cycle comparison, directed cases and random traffic.

module tb_execute_stage_mdu;
  import execute_stage_mdu_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_BPC = 4;
  localparam int RD_W    = 5;
  localparam int MUL_LAT = XLEN / MUL_BPC + 1;
  localparam int DIV_LAT = XLEN + 1;

  logic              clk, reset_n, flush;
  logic              in_valid, in_ready, in_wbv;
  decoded_instr_name in_op, out_op;
  logic [XLEN-1:0]   in_rs1, in_rs2, in_imm, in_pc_plus_4;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic              out_valid, out_ready, out_wbv, out_is_load, stall;
  logic [XLEN-1:0]   out_result, out_store_data;

  execute_stage_mdu #(.XLEN(XLEN), .MUL_BPC(MUL_BPC), .RD_W(RD_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc_plus_4(in_pc_plus_4),
    .in_rd(in_rd), .in_wbv(in_wbv),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_wbv(out_wbv),
    .out_is_load(out_is_load), .out_op(out_op), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_result(input decoded_instr_name op,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc4);
    logic [4:0]  sr, si;
    logic [63:0] p;
    sr = b[4:0];
    si = imm[4:0];
    case (op)
      OP_LUI:                   return imm;
      OP_AUIPC:                 return pc4 - 32'd4 + imm;
      OP_JAL, OP_JALR:          return pc4;
      OP_BEQ:                   return {31'b0, a == b};
      OP_BNE:                   return {31'b0, a != b};
      OP_BLT:                   return {31'b0, int'(a) < int'(b)};
      OP_BGE:                   return {31'b0, int'(a) >= int'(b)};
      OP_BLTU:                  return {31'b0, a < b};
      OP_BGEU:                  return {31'b0, a >= b};
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_ADDI: return a + imm;
      OP_SLTI:                  return {31'b0, int'(a) < int'(imm)};
      OP_SLTIU:                 return {31'b0, a < imm};
      OP_XORI:                  return a ^ imm;
      OP_ORI:                   return a | imm;
      OP_ANDI:                  return a & imm;
      OP_SLLI:                  return a << si;
      OP_SRLI:                  return a >> si;
      OP_SRAI:                  return 32'(int'(a) >>> si);
      OP_ADD:                   return a + b;
      OP_SUB:                   return a - b;
      OP_SLL:                   return a << sr;
      OP_SLT:                   return {31'b0, int'(a) < int'(b)};
      OP_SLTU:                  return {31'b0, a < b};
      OP_XOR:                   return a ^ b;
      OP_SRL:                   return a >> sr;
      OP_SRA:                   return 32'(int'(a) >>> sr);
      OP_OR:                    return a | b;
      OP_AND:                   return a & b;
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = longint'(int'(a)) * longint'(int'(b)); return p[63:32]; end
      OP_MULHSU: begin p = longint'(int'(a)) * longint'({32'b0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(int'(a) / int'(b));
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(int'(a) % int'(b));
      end
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int model_latency(input decoded_instr_name op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return MUL_LAT;
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
      if (b == 0) return 1;
      if ((op inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return DIV_LAT;
    end
    return 1;
  endfunction

  typedef struct {
    logic [31:0]       result;
    logic [31:0]       sd;
    logic [RD_W-1:0]   rd;
    logic              wbv;
    logic              is_load;
    decoded_instr_name op;
  } out_t;

  logic m_valid;
  int   m_busy;    // cycles of stall still to come before the pending op lands
  out_t m_out, m_pend;

  // Model update at each edge: completion, accept, then output register behaviour
  always @(posedge clk or negedge reset_n) begin : model
    logic free, rdy, land, nvalid;
    int   nbusy, lat;
    out_t nxt, t;
    if (!reset_n) begin
      m_valid     <= 1'b0;
      m_busy      <= 0;
      m_out       <= '{result: 0, sd: 0, rd: 0, wbv: 0, is_load: 0, op: OP_NOP};
      m_pend      <= '{result: 0, sd: 0, rd: 0, wbv: 0, is_load: 0, op: OP_NOP};
    end else if (flush) begin
      m_valid <= 1'b0;
      m_busy  <= 0;
    end else begin
      free   = !m_valid || out_ready;
      rdy    = (m_busy == 0) && free;
      land   = 1'b0;
      nbusy  = m_busy;
      nxt    = m_out;
      if (m_busy == 1 && free) begin
        land  = 1'b1;
        nxt   = m_pend;
        nbusy = 0;
      end else if (m_busy > 1) begin
        nbusy = m_busy - 1;
      end
      if (in_valid && rdy) begin
        t.result  = model_result(in_op, in_rs1, in_rs2, in_imm, in_pc_plus_4);
        t.sd      = in_rs2;
        t.rd      = in_rd;
        t.wbv     = in_wbv;
        t.is_load = in_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        t.op      = in_op;
        lat = model_latency(in_op, in_rs1, in_rs2);
        if (lat == 1) begin
          land = 1'b1;
          nxt  = t;
        end else begin
          m_pend <= t;
          nbusy  = lat - 1;
        end
      end
      nvalid = land ? 1'b1 : (out_ready ? 1'b0 : m_valid);
      m_valid <= nvalid;
      m_busy  <= nbusy;
      if (land) m_out <= nxt;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (reset_n) begin
      check("in_ready", in_ready, (m_busy == 0) && (!m_valid || out_ready));
      check("stall", stall, m_busy != 0);
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("out_result", out_result, m_out.result);
        check("out_store_data", out_store_data, m_out.sd);
        check("out_rd", out_rd, m_out.rd);
        check("out_wbv", out_wbv, m_out.wbv);
        check("out_is_load", out_is_load, m_out.is_load);
        check("out_op", out_op, m_out.op);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present an op and hold it until accepted; returns at accept edge + 1
  task automatic issue(input decoded_instr_name op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    logic acc;
    acc          = 1'b0;
    in_valid     = 1'b1;
    in_op        = op;
    in_rs1       = a;
    in_rs2       = b;
    in_imm       = imm;
    in_pc_plus_4 = $urandom;
    in_rd        = RD_W'($urandom);
    in_wbv       = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("issue_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid; also counts stall and in_ready cycles before it
  task automatic wait_out(output int lat, output logic [31:0] res, output int stall_cyc,
                          output int rdy_cyc);
    lat = -1; res = '0; stall_cyc = 0; rdy_cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        res = out_result;
        break;
      end
      if (stall) stall_cyc++;
      if (in_ready) rdy_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, sc, rc;
    logic [31:0] res;
    decoded_instr_name rop;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = OP_NOP;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc_plus_4 = '0; in_rd = '0; in_wbv = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_stall", stall, 0);
    check("reset_out_result", out_result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(OP_ADDI, 32'd5, 32'd0, -32'd7);
    wait_out(lat, res, sc, rc);
    check("addi_latency", lat, 1);
    check("addi_result", res, 32'hFFFF_FFFE);

    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    wait_out(lat, res, sc, rc);
    check("mulhu_latency", lat, 9);
    check("mulhu_stall_cycles", sc, 8);
    check("mulhu_result", res, 32'hFFFF_FFFE);

    issue(OP_DIV, -32'd7, 32'd2, 32'd0);
    wait_out(lat, res, sc, rc);
    check("div_latency", lat, 33);
    check("div_in_ready_cycles", rc, 0);
    check("div_result", res, 32'hFFFF_FFFD);

    issue(OP_REM, -32'd7, 32'd2, 32'd0);
    wait_out(lat, res, sc, rc);
    check("rem_latency", lat, 33);
    check("rem_result", res, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd1234, 32'd0, 32'd0);
    wait_out(lat, res, sc, rc);
    check("divu_zero_latency", lat, 1);
    check("divu_zero_result", res, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_out(lat, res, sc, rc);
    check("div_ovf_latency", lat, 1);
    check("div_ovf_result", res, 32'h8000_0000);

    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_out(lat, res, sc, rc);
    check("rem_ovf_latency", lat, 1);
    check("rem_ovf_result", res, 32'h0);

    // Output hold with a second op waiting, then back-to-back release
    issue(OP_ADD, 32'd3, 32'd4, 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ADDI; in_rs1 = 32'd100; in_imm = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, 32'd7);
      check("hold_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_result", out_result, 32'd7);
    check("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", out_valid, 1);
    check("b2b_result", out_result, 32'd101);
    @(posedge clk);
    #1;

    // Flush in cycle 10 of a divide
    issue(OP_DIV, 32'd100, 32'd7, 32'd0);
    for (int k = 0; k < 9; k++) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_stall", stall, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    issue(OP_ADD, 32'd1, 32'd2, 32'd0);
    wait_out(lat, res, sc, rc);
    check("post_flush_result", res, 32'd3);

    // Asynchronous reset pulse in the middle of a multiply
    issue(OP_MUL, 32'd9, 32'd9, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_stall", stall, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_MUL, 32'd6, 32'd7, 32'd0);
    wait_out(lat, res, sc, rc);
    check("post_reset_mul_latency", lat, 9);
    check("post_reset_mul_result", res, 32'd42);

    // Random traffic, checked every cycle by the compare process
    repeat (2000) begin
      rop = rop.first();
      repeat ($urandom_range(0, rop.num() - 1)) rop = rop.next();
      in_op        = rop;
      in_valid     = ($urandom_range(0, 2) != 0);
      in_rs1       = rand_val();
      in_rs2       = rand_val();
      in_imm       = rand_val();
      in_pc_plus_4 = $urandom;
      in_rd        = RD_W'($urandom);
      in_wbv       = 1'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
